// File: rtl/ultrasonic_scan_scheduler_if.sv
// ultrasonic_scan_scheduler_if: sensor pins, scan control and measurement results of the scan scheduler
interface ultrasonic_scan_scheduler_if #(
  parameter int NUM_SENSORS = 4,
  parameter int CNT_W       = 22
);
  logic                   enable;
  logic [NUM_SENSORS-1:0] sensor_mask;
  logic [NUM_SENSORS-1:0] echo;
  logic [NUM_SENSORS-1:0] trig;
  logic [2:0]             cur_sensor;
  logic                   busy;
  logic                   meas_valid;
  logic [2:0]             meas_id;
  logic [CNT_W-1:0]       meas_cycles;
  logic                   meas_timeout;
  logic [NUM_SENSORS-1:0] obj_det;
  logic                   any_obj;
  modport master (
    output enable, sensor_mask, echo,
    input  trig, cur_sensor, busy, meas_valid, meas_id, meas_cycles, meas_timeout, obj_det, any_obj
  );
  modport slave (
    input  enable, sensor_mask, echo,
    output trig, cur_sensor, busy, meas_valid, meas_id, meas_cycles, meas_timeout, obj_det, any_obj
  );
endinterface

// File: rtl/ultrasonic_scan_scheduler.sv
// ultrasonic_scan_scheduler: round-robin HC-SR04 trigger/echo timing with per-sensor obstacle flags
module ultrasonic_scan_scheduler #(
  parameter int NUM_SENSORS   = 4,
  parameter int TRIG_CYCLES   = 500,
  parameter int ECHO_TIMEOUT  = 1900000,
  parameter int SLOT_CYCLES   = 3000000,
  parameter int THRESH_CYCLES = 29070,
  parameter int CNT_W         = 22
) (
  input logic clk,
  input logic rst_n,
  ultrasonic_scan_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GUARD} state_t;
  state_t                 r_state;
  logic [NUM_SENSORS-1:0] r_s1, r_s2, r_d, r_trig, r_obj;
  logic [2:0]             r_cur, r_id;
  logic [CNT_W-1:0]       r_cnt, r_slot, r_meas;
  logic                   r_valid, r_to, r_any;
  logic [NUM_SENSORS-1:0] w_rot, w_sel, w_obj, w_now_v, w_prev_v;
  logic [2:0]             w_next;
  logic                   w_now, w_prev, w_rise, w_last, w_res, w_res_to, w_hit, w_go, w_launch;
  always_comb begin
    w_next = r_cur;
    w_rot  = '0;
    for (int k = NUM_SENSORS; k >= 1; k--) begin
      w_rot = bus.sensor_mask >> ((int'(r_cur) + k) % NUM_SENSORS);
      if (w_rot[0]) w_next = 3'((int'(r_cur) + k) % NUM_SENSORS);
    end
  end
  // r_d is the synchronized echo one cycle later: edge reference and the sample counted in MEASURE
  always_comb begin
    w_now_v  = r_s2 >> r_cur;
    w_prev_v = r_d >> r_cur;
    w_now    = w_now_v[0];
    w_prev   = w_prev_v[0];
    w_rise   = w_now & ~w_prev;
    w_last   = r_cnt == CNT_W'(ECHO_TIMEOUT - 1);
    w_res    = (r_state == WAIT_RISE && !w_rise && w_last) || (r_state == MEASURE && (!w_prev || w_last));
    w_res_to = (r_state == WAIT_RISE) || w_prev;
    w_hit    = w_res && !w_res_to && r_cnt < CNT_W'(THRESH_CYCLES);
    w_sel    = NUM_SENSORS'(1) << r_cur;
    w_obj    = (w_res ? ((r_obj & ~w_sel) | (w_hit ? w_sel : '0)) : r_obj) & bus.sensor_mask;
    w_go     = bus.enable && |bus.sensor_mask;
    w_launch = w_go && (r_state == IDLE || (r_state == GUARD && r_slot == CNT_W'(SLOT_CYCLES - 1)));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_s1    <= '0;
      r_s2    <= '0;
      r_d     <= '0;
      r_trig  <= '0;
      r_obj   <= '0;
      r_cur   <= 3'(NUM_SENSORS - 1);
      r_id    <= '0;
      r_cnt   <= '0;
      r_slot  <= '0;
      r_meas  <= '0;
      r_valid <= 1'b0;
      r_to    <= 1'b0;
      r_any   <= 1'b0;
    end else begin
      r_s1    <= bus.echo;
      r_s2    <= r_s1;
      r_d     <= r_s2;
      r_obj   <= w_obj;
      r_any   <= |r_obj;
      r_valid <= w_res;
      if (w_res) begin
        r_id   <= r_cur;
        r_meas <= w_res_to ? '0 : r_cnt;
        r_to   <= w_res_to;
      end
      r_slot <= w_launch ? '0 : (r_state != IDLE ? r_slot + 1'b1 : r_slot);
      if (w_launch) begin
        r_cur   <= w_next;
        r_trig  <= NUM_SENSORS'(1) << w_next;
        r_cnt   <= '0;
        r_state <= TRIG;
      end else begin
        case (r_state)
          TRIG:
            if (r_cnt == CNT_W'(TRIG_CYCLES - 1)) begin
              r_trig  <= '0;
              r_cnt   <= '0;
              r_state <= WAIT_RISE;
            end else r_cnt <= r_cnt + 1'b1;
          WAIT_RISE:
            if (w_rise) begin
              r_cnt   <= '0;
              r_state <= MEASURE;
            end else if (w_res) r_state <= GUARD;
            else r_cnt <= r_cnt + 1'b1;
          MEASURE:
            if (w_res) r_state <= GUARD;
            else r_cnt <= r_cnt + 1'b1;
          GUARD:
            if (r_slot == CNT_W'(SLOT_CYCLES - 1)) r_state <= IDLE;
          IDLE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end
  assign bus.trig         = r_trig;
  assign bus.cur_sensor   = r_cur;
  assign bus.busy         = r_state != IDLE;
  assign bus.meas_valid   = r_valid;
  assign bus.meas_id      = r_id;
  assign bus.meas_cycles  = r_meas;
  assign bus.meas_timeout = r_to;
  assign bus.obj_det      = r_obj;
  assign bus.any_obj      = r_any;
endmodule
